// File: rtl/dphy_hs_burst_arbiter_if.sv
// Handshake bundle between the link-layer packet sources, the HS burst
// arbiter and the DPHY_LPTX low-power transmitter.
interface dphy_hs_burst_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic               Enable;
  logic [NUM_REQ-1:0] Req;
  logic               HSTX_EN;
  logic               LPTX_EN;
  logic               TxRequestHS;
  logic [NUM_REQ-1:0] Grant;
  logic               HsReady;
  logic               Err;

  // Requester / LPTX side: drives requests and the HS enable status.
  modport master (
    output Enable, Req, HSTX_EN,
    input  LPTX_EN, TxRequestHS, Grant, HsReady, Err
  );

  // Arbiter side.
  modport slave (
    input  Enable, Req, HSTX_EN,
    output LPTX_EN, TxRequestHS, Grant, HsReady, Err
  );
endinterface

// File: rtl/dphy_hs_burst_arbiter.sv
// Round-robin arbiter sharing one D-PHY HS data lane among NUM_REQ packet
// sources: grants the lane, requests HS from the LPTX, bounds the HS window,
// sequences HS exit and enforces a stop-state gap between bursts.
module dphy_hs_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_MAX  = 64,
  parameter int GAP_TIME   = 8,
  parameter int HS_TIMEOUT = 32
) (
  input  logic                    LPTX_CLK,
  input  logic                    TxRst_n,
  dphy_hs_burst_arbiter_if.slave  bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(HS_TIMEOUT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int GW = $clog2(GAP_TIME + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_HS = 3'd1;
  localparam logic [2:0] S_BURST  = 3'd2;
  localparam logic [2:0] S_EXIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [PW-1:0]      rr_ptr, ptr_nxt;
  logic [WW-1:0]      wait_cnt, wait_nxt;
  logic [BW-1:0]      burst_cnt, burst_nxt;
  logic [GW-1:0]      gap_cnt, gap_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic               txreq_q, txreq_nxt;
  logic               rdy_q, rdy_nxt;
  logic               lptx_en_q;
  logic               err_q, err_pend, err_evt;
  logic               found;
  logic [PW-1:0]      win_idx;
  logic               req_g;
  logic               wait_hit, burst_hit, gap_hit;

  assign req_g     = |(bus.Req & grant_q);
  assign wait_hit  = (wait_cnt  >= WW'(HS_TIMEOUT - 1));
  assign burst_hit = (burst_cnt >= BW'(BURST_MAX - 1));
  assign gap_hit   = (gap_cnt   >= GW'(GAP_TIME - 1));

  // Round-robin pick: lowest requester above the pointer, else lowest overall.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && bus.Req[j] && (j > 32'(rr_ptr))) begin
        found   = 1'b1;
        win_idx = PW'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && bus.Req[j]) begin
        found   = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  // Next-state and next-output decode for the lane ownership FSM.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    grant_nxt = grant_q;
    txreq_nxt = txreq_q;
    rdy_nxt   = rdy_q;
    err_evt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Enable && found) begin
          grant_nxt = NUM_REQ'(1) << win_idx;
          ptr_nxt   = win_idx;
          txreq_nxt = 1'b1;
          state_nxt = S_REQ_HS;
        end
      end
      S_REQ_HS: begin
        if (bus.HSTX_EN) begin
          rdy_nxt   = 1'b1;
          state_nxt = S_BURST;
        end else if (!req_g || !bus.Enable) begin
          state_nxt = S_EXIT;
        end else if (wait_hit) begin
          err_evt   = 1'b1;
          state_nxt = S_EXIT;
        end
      end
      S_BURST: begin
        if (!bus.HSTX_EN) begin
          err_evt   = 1'b1;
          state_nxt = S_EXIT;
        end else if (!req_g || burst_hit || !bus.Enable) begin
          state_nxt = S_EXIT;
        end
      end
      S_EXIT: begin
        if (!bus.HSTX_EN) begin
          state_nxt = S_GAP;
        end else if (wait_hit) begin
          err_evt   = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_hit) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Lane is released on the same edge the FSM leaves REQ_HS/BURST.
    if (state_nxt == S_EXIT && state != S_EXIT) begin
      txreq_nxt = 1'b0;
      rdy_nxt   = 1'b0;
      grant_nxt = '0;
    end
    if (state_nxt == S_IDLE && state != S_IDLE) begin
      txreq_nxt = 1'b0;
      rdy_nxt   = 1'b0;
      grant_nxt = '0;
    end
  end

  // Saturating per-state counters, cleared on every state change.
  always_comb begin
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    gap_nxt   = gap_cnt;
    if (state_nxt != state) begin
      wait_nxt  = '0;
      burst_nxt = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        S_REQ_HS, S_EXIT: if (wait_cnt != WW'(HS_TIMEOUT)) wait_nxt = wait_cnt + 1'b1;
        S_BURST:          if (burst_cnt != BW'(BURST_MAX)) burst_nxt = burst_cnt + 1'b1;
        S_GAP:            if (gap_cnt != GW'(GAP_TIME)) gap_nxt = gap_cnt + 1'b1;
        default:          ;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge LPTX_CLK or negedge TxRst_n) begin
    if (!TxRst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= PW'(NUM_REQ - 1);
      wait_cnt  <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      grant_q   <= '0;
      txreq_q   <= 1'b0;
      rdy_q     <= 1'b0;
      lptx_en_q <= 1'b0;
      err_q     <= 1'b0;
      err_pend  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= ptr_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
      gap_cnt   <= gap_nxt;
      grant_q   <= grant_nxt;
      txreq_q   <= txreq_nxt;
      rdy_q     <= rdy_nxt;
      lptx_en_q <= bus.Enable;
      // An error arriving while Err is already high is held one cycle so
      // back-to-back events still appear as separate pulses.
      err_q     <= (err_evt | err_pend) & ~err_q;
      err_pend  <= (err_evt | err_pend) & err_q;
    end
  end

  assign bus.LPTX_EN     = lptx_en_q;
  assign bus.TxRequestHS = txreq_q;
  assign bus.Grant       = grant_q;
  assign bus.HsReady     = rdy_q;
  assign bus.Err         = err_q;

endmodule

// File: tb/tb_dphy_hs_burst_arbiter.sv
// Directed bench for dphy_hs_burst_arbiter: a per-cycle vector table for the
// normal burst / gap / enable sequence, plus hand-written multi-cycle cases.
module tb_dphy_hs_burst_arbiter;
  localparam int N    = 4;
  localparam int BMAX = 64;
  localparam int GAP  = 8;
  localparam int TO   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dphy_hs_burst_arbiter_if #(.NUM_REQ(N)) bus ();

  dphy_hs_burst_arbiter #(
    .NUM_REQ(N), .BURST_MAX(BMAX), .GAP_TIME(GAP), .HS_TIMEOUT(TO)
  ) dut (
    .LPTX_CLK(clk),
    .TxRst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       hs;
    logic [7:0] exp; // {LPTX_EN, TxRequestHS, Grant[3:0], HsReady, Err}
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic en, logic [3:0] req, logic hs,
                              logic lptx, logic txr, logic [3:0] g, logic rdy);
    vec_t v;
    v.en  = en;
    v.req = req;
    v.hs  = hs;
    v.exp = {lptx, txr, g, rdy, 1'b0};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  function automatic logic [7:0] outs();
    return {bus.LPTX_EN, bus.TxRequestHS, bus.Grant, bus.HsReady, bus.Err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.Enable  = 1'b0;
    bus.Req     = '0;
    bus.HSTX_EN = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_txreq();
    int c = 0;
    while (!bus.TxRequestHS && c < 50) begin
      step();
      c++;
    end
    check("txreq_wait", 32'(bus.TxRequestHS), 32'd1);
  endtask

  // One capped burst with Req held: expects owner idx and exactly BMAX HsReady cycles.
  task automatic rr_burst(input int idx);
    int cnt = 0;
    int e   = 0;
    wait_txreq();
    check($sformatf("rr_grant%0d", idx), 32'(bus.Grant), 32'(4'b0001 << idx));
    step();
    bus.HSTX_EN = 1'b1;
    step();
    while (bus.HsReady && cnt < 200) begin
      cnt++;
      if (bus.Err) e++;
      step();
    end
    check("rr_burst_len", cnt, BMAX);
    check("rr_exit", 32'({bus.TxRequestHS, bus.Grant, bus.Err}), 32'd0);
    check("rr_no_err", e, 0);
    bus.HSTX_EN = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    bus.Enable  = 1'b0;
    bus.Req     = '0;
    bus.HSTX_EN = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("reset_async", 32'(outs()), 32'd0);
    step();
    step();
    check("reset_held", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    // Normal burst of Req[2] (20 cycles), gap length, then Enable drop in REQ_HS.
    add(1,  1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    add(5,  1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0);
    add(15, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1);
    add(3,  1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    add(1,  1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    add(8,  1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    add(1,  1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    add(3,  1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    foreach (vecs[i]) begin
      bus.Enable  = vecs[i].en;
      bus.Req     = vecs[i].req;
      bus.HSTX_EN = vecs[i].hs;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Timeout in REQ_HS, then requester 1 takes the next grant.
    do_reset();
    bus.Enable = 1'b1;
    bus.Req    = 4'b0011;
    step();
    check("to_grant", 32'({bus.TxRequestHS, bus.Grant}), 32'(5'b1_0001));
    bad = 0;
    for (int k = 1; k < TO; k++) begin
      step();
      if (bus.Err || !bus.TxRequestHS) bad++;
    end
    check("to_wait", bad, 0);
    step();
    check("to_err", 32'({bus.Err, bus.TxRequestHS, bus.Grant}), 32'(6'b10_0000));
    step();
    check("to_err_pulse", 32'(bus.Err), 32'd0);
    bad = 0;
    for (int k = 0; k < GAP; k++) begin
      step();
      if (bus.TxRequestHS || bus.Grant != 0) bad++;
    end
    check("to_gap", bad, 0);
    step();
    check("to_rr_next", 32'({bus.TxRequestHS, bus.Grant}), 32'(5'b1_0010));

    // HS abort mid-burst.
    bus.HSTX_EN = 1'b1;
    step();
    check("ab_ready", 32'(bus.HsReady), 32'd1);
    step();
    step();
    step();
    check("ab_still", 32'({bus.HsReady, bus.Grant}), 32'(5'b1_0010));
    bus.HSTX_EN = 1'b0;
    step();
    check("ab_err", 32'({bus.Err, bus.HsReady, bus.TxRequestHS, bus.Grant}), 32'(7'b100_0000));
    step();
    check("ab_err_pulse", 32'(bus.Err), 32'd0);

    // Enable drop mid-burst; no grants while disabled.
    wait_txreq();
    check("en_grant", 32'(bus.Grant), 32'(4'b0001));
    bus.HSTX_EN = 1'b1;
    step();
    check("en_ready", 32'(bus.HsReady), 32'd1);
    step();
    step();
    bus.Enable = 1'b0;
    step();
    check("en_drop", 32'(outs()), 32'd0);
    bus.HSTX_EN = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.Grant != 0 || bus.TxRequestHS || bus.Err) bad++;
    end
    check("en_no_grant", bad, 0);

    // Reset mid-burst: outputs clear asynchronously, RR restarts at 0.
    bus.Enable = 1'b1;
    wait_txreq();
    bus.HSTX_EN = 1'b1;
    step();
    step();
    check("rst_in_burst", 32'(bus.HsReady), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", 32'(outs()), 32'd0);
    bus.Req     = 4'b1111;
    bus.HSTX_EN = 1'b0;
    step();
    rst_n = 1'b1;
    rr_burst(0);
    rr_burst(1);
    rr_burst(2);
    rr_burst(3);
    rr_burst(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dphy_hs_burst_arbiter.md
# dphy_hs_burst_arbiter

Shares one D-PHY data lane, driven through the `DPHY_LPTX` low-power transmitter, among `NUM_REQ` high-speed packet requesters. It grants the lane round-robin and raises `TxRequestHS` for the winner. It waits for `HSTX_EN` from the LPTX, opens an HS window of bounded length, and sequences the HS exit. It then enforces a minimum stop-state gap before the next grant. It sits between the link-layer packet sources and `DPHY_LPTX`, in the `LPTX_CLK` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `BURST_MAX`, default 64: maximum `HsReady` cycles per grant (≥1).
- `GAP_TIME`, default 8: stop-state cycles between bursts (≥1).
- `HS_TIMEOUT`, default 32: maximum cycles waiting on `HSTX_EN` edges (≥1).

Ports:
- `LPTX_CLK`, input, 1: the only clock. All logic is rising-edge.
- `TxRst_n`, input, 1: asynchronous, active-low reset.
- `Enable`, input, 1: arbiter enable.
- `Req`, input, NUM_REQ: per-requester lane request, held high for the whole burst.
- `HSTX_EN`, input, 1: HS transmitter enabled, from `DPHY_LPTX`.
- `LPTX_EN`, output, 1: enable to `DPHY_LPTX`.
- `TxRequestHS`, output, 1: HS request to `DPHY_LPTX`.
- `Grant`, output, NUM_REQ: one-hot owner, or zero when the lane is unowned.
- `HsReady`, output, 1: the granted requester may present HS data this cycle.
- `Err`, output, 1: one-cycle pulse on timeout or HS abort.

## Operation
- All outputs are registered.
- Reset values:
  - `LPTX_EN`=0, `TxRequestHS`=0, `Grant`=0, `HsReady`=0, `Err`=0.
  - State=IDLE, counters=0.
  - RR pointer=NUM_REQ-1, so requester 0 wins first.
- `LPTX_EN` equals `Enable` delayed by one register, in all states.
- FSM states:
  - **IDLE**
    - If `Enable`=1 and `Req`≠0, pick the first set bit scanning upward from pointer+1 modulo NUM_REQ.
    - On that edge: `Grant`=winner, pointer=winner index, `TxRequestHS`=1, go to REQ_HS.
  - **REQ_HS** (wait counter increments each cycle)
    - `HSTX_EN`=1: go to BURST and set `HsReady`=1.
    - Wait counter reaches HS_TIMEOUT: pulse `Err`, go to EXIT.
    - Granted `Req` bit drops, or `Enable`=0: go to EXIT with no `Err`.
  - **BURST** (burst counter counts `HsReady` cycles)
    - The burst ends when any of these holds: the granted `Req` bit is 0, burst count = BURST_MAX, or `Enable`=0.
    - If `HSTX_EN` drops while still in BURST: pulse `Err` and end the burst.
    - On ending: go to EXIT.
  - **Entering EXIT** (from REQ_HS or BURST): on that edge `TxRequestHS`=0, `HsReady`=0, `Grant`=0.
  - **EXIT**
    - `HSTX_EN`=0: go to GAP.
    - Otherwise, after HS_TIMEOUT cycles: pulse `Err` and go to GAP anyway.
  - **GAP**: stay exactly GAP_TIME cycles, then go to IDLE.
- Arbitration happens only in IDLE. A request arriving during BURST, EXIT or GAP waits.
- Simultaneous requests are resolved by RR order only. There is no fixed priority apart from the reset pointer.
- Counters are sized `$clog2(param+1)` bits, saturate at the limit and clear on every state change.
- `Err` never stays high more than one cycle. Two error events in consecutive cycles give two separate pulses.
- Asynchronous reset mid-operation returns everything to the reset values immediately. The LPTX sees `TxRequestHS` fall asynchronously.

## Timing
- Latency from `Req` rising (in IDLE, `Enable`=1) to `Grant`/`TxRequestHS` high: 1 edge.
- Latency from `HSTX_EN` rising to `HsReady` high: 1 edge.
- `HsReady` is high for min(requester hold, BURST_MAX) cycles.
  - The cap case ends after exactly BURST_MAX `HsReady` cycles.
  - Requester release is seen 1 cycle late, so `HsReady` falls 1 edge after `Req` falls.
- Minimum time from `TxRequestHS` falling to the next `TxRequestHS` rising: (EXIT cycles) + GAP_TIME + 1.
- `Grant` changes only on entering REQ_HS (set) and entering EXIT (cleared). It never changes between two owners directly.

## Test plan
- **Single requester, normal burst.**
  - Stimulus: `Req[2]` held 20 cycles. The LPTX model asserts `HSTX_EN` 5 cycles after `TxRequestHS` and drops it 3 cycles after release.
  - Required: `Grant`=4'b0100. `HsReady` rises 1 cycle after `HSTX_EN` and stays high until 1 edge after `Req[2]` falls. GAP lasts 8 cycles. `Err` stays 0.
- **Round-robin.**
  - Stimulus: `Req`=4'b1111 held continuously.
  - Required: grant order is 0,1,2,3,0. Every burst is exactly 64 `HsReady` cycles.
- **Timeout.**
  - Stimulus: `Req[0]`=1, `HSTX_EN` tied 0.
  - Required: `Err` pulses 1 cycle, 32 cycles after `TxRequestHS` rises. `TxRequestHS` drops on the same edge, then the FSM goes to GAP and IDLE. After the gap, arbitration restarts and requester 1 has RR priority if it is also requesting.
- **HS abort.**
  - Stimulus: `HSTX_EN` dropped mid-BURST.
  - Required: a one-cycle `Err` pulse. `HsReady`, `TxRequestHS` and `Grant` go to 0 on the next edge.
- **Enable drop.**
  - Stimulus: `Enable`=0 mid-BURST.
  - Required: `LPTX_EN` falls 1 edge later and the burst ends. No new `Grant` is issued while `Enable`=0, even with `Req`≠0.
- **Reset mid-burst.**
  - Stimulus: pull `TxRst_n` low during BURST.
  - Required: all outputs 0 asynchronously. After release, `Req`=4'b1111 gives the first grant to requester 0.
